dcpu_timer: RTL



---
 rtl/dcpu_pkg.sv | 31 +++
 rtl/dcpu_bus_responder.sv | 85 ++++++++
 rtl/dcpu_timer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dcpu_pkg.sv
// Shared dcpu peripheral definitions: register offsets, CTRL/STATUS bit
// positions, bus handshake state encoding and the latched bus request.
package dcpu_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_RELOAD   = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_ID       = 3'd5;
  localparam logic [2:0] REG_MISS     = 3'd6;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_ACK  = 2'd2
  } bus_state_e;

  // Access captured in IDLE and held until the ack cycle completes.
  typedef struct packed {
    logic [2:0]  off;
    logic        we;
    logic [15:0] dat;
  } bus_req_t;

endpackage

// File: rtl/dcpu_bus_responder.sv
// Generic dcpu bus responder: decodes an 8-word window at BASE_ADDR, latches
// the access, inserts WAIT_STATES wait cycles and produces a one-cycle ack.
// Register blocks commit writes on the edge leaving the ack cycle (o_wr_stb)
// and drive read data during the ack cycle (o_rd_stb).
module dcpu_bus_responder
  import dcpu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [2:0]  o_off,
  output logic [15:0] o_wdat,
  output logic        o_wr_stb,
  output logic        o_rd_stb,
  output logic        o_ack
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  bus_state_e state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  bus_req_t   req, req_nxt;
  logic       hit;

  assign hit = i_cs && (i_addr[15:3] == BASE_ADDR[15:3]);

  // Handshake state, wait counter and request latch.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= BUS_IDLE;
      wcnt  <= 4'd0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      req   <= req_nxt;
    end
  end

  // Next state: IDLE samples a hit, WAIT counts down (dropping cs aborts),
  // ACK lasts exactly one cycle so a held cs is only re-sampled in IDLE.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    req_nxt   = req;
    case (state)
      BUS_IDLE: begin
        if (hit) begin
          req_nxt.off = i_addr[2:0];
          req_nxt.we  = i_we;
          req_nxt.dat = i_dat;
          if (WS != 4'd0) begin
            state_nxt = BUS_WAIT;
            wcnt_nxt  = WS;
          end else begin
            state_nxt = BUS_ACK;
          end
        end
      end
      BUS_WAIT: begin
        if (!i_cs) begin
          state_nxt = BUS_IDLE;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
          if (wcnt == 4'd1) state_nxt = BUS_ACK;
        end
      end
      BUS_ACK:  state_nxt = BUS_IDLE;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  assign o_ack    = (state == BUS_ACK);
  assign o_wr_stb = o_ack && req.we;
  assign o_rd_stb = o_ack && !req.we;
  assign o_off    = req.off;
  assign o_wdat   = req.dat;

endmodule

// File: rtl/dcpu_timer.sv
// dcpu timer peripheral: prescaled 16-bit down-counter with optional
// auto-reload and a level interrupt (o_int = EXP & IE) behind an 8-word
// register window served by dcpu_bus_responder.
// Optional: define DCPU_TIMER_MISS_COUNT_EN to add the saturating MISS
// counter at offset 6 (expiries that occur while EXP is still set).
module dcpu_timer
  import dcpu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] ID_VALUE    = 16'hD71E
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack,
  output logic        o_int
);

  logic [2:0]  off;
  logic [15:0] wdat;
  logic        wr_stb, rd_stb;

  dcpu_bus_responder #(
    .BASE_ADDR   (BASE_ADDR),
    .WAIT_STATES (WAIT_STATES)
  ) u_bus (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_cs      (i_cs),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_dat     (i_dat),
    .o_off     (off),
    .o_wdat    (wdat),
    .o_wr_stb  (wr_stb),
    .o_rd_stb  (rd_stb),
    .o_ack     (o_ack)
  );

  logic        ctrl_en, ctrl_auto, ctrl_ie;
  logic [15:0] presc, reload, count, pcnt;
  logic        exp_flag;
  logic        wr_ctrl, wr_presc, wr_reload, wr_count, wr_status;
  logic        tick, expire;
  logic [15:0] rdat;

  assign wr_ctrl   = wr_stb && (off == REG_CTRL);
  assign wr_presc  = wr_stb && (off == REG_PRESCALE);
  assign wr_reload = wr_stb && (off == REG_RELOAD);
  assign wr_count  = wr_stb && (off == REG_COUNT);
  assign wr_status = wr_stb && (off == REG_STATUS);

  assign tick   = ctrl_en && (pcnt == presc);
  assign expire = tick && (count == 16'd0);

  // Prescaler: restarts on a COUNT write or when EN goes 0->1 so the first
  // period after (re)arming is always a full PRESCALE+1 cycles.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                          pcnt <= 16'd0;
    else if (wr_count || (wr_ctrl && wdat[CTRL_EN] && !ctrl_en)) pcnt <= 16'd0;
    else if (ctrl_en)                                        pcnt <= tick ? 16'd0 : pcnt + 16'd1;
  end

  // CTRL: a software write overrides the one-shot EN clear on expiry.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en   <= wdat[CTRL_EN];
      ctrl_auto <= wdat[CTRL_AUTO];
      ctrl_ie   <= wdat[CTRL_IE];
    end else if (expire && !ctrl_auto) begin
      ctrl_en   <= 1'b0;
    end
  end

  // PRESCALE and RELOAD are plain software registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc  <= 16'd0;
      reload <= 16'd0;
    end else begin
      if (wr_presc)  presc  <= wdat;
      if (wr_reload) reload <= wdat;
    end
  end

  // COUNT: a software write beats a tick on the same edge; one-shot expiry
  // leaves COUNT parked at 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                      count <= 16'd0;
    else if (wr_count)                   count <= wdat;
    else if (tick && count != 16'd0)     count <= count - 16'd1;
    else if (expire && ctrl_auto)        count <= reload;
  end

  // EXP: set on expiry, write-1-to-clear; a same-edge set wins.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                          exp_flag <= 1'b0;
    else if (expire)                         exp_flag <= 1'b1;
    else if (wr_status && wdat[STATUS_EXP])  exp_flag <= 1'b0;
  end

`ifdef DCPU_TIMER_MISS_COUNT_EN
  logic [15:0] miss;
  logic        wr_miss;

  assign wr_miss = wr_stb && (off == REG_MISS);

  // MISS: counts expiries that software has not yet acknowledged; saturates.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                     miss <= 16'd0;
    else if (wr_miss)                                   miss <= 16'd0;
    else if (expire && exp_flag && miss != 16'hFFFF)    miss <= miss + 16'd1;
  end
`endif

  // Read mux over the latched offset; unused bits and slots read 0.
  always_comb begin
    rdat = 16'd0;
    case (off)
      REG_CTRL:     rdat = {13'd0, ctrl_ie, ctrl_auto, ctrl_en};
      REG_PRESCALE: rdat = presc;
      REG_RELOAD:   rdat = reload;
      REG_COUNT:    rdat = count;
      REG_STATUS:   rdat = {15'd0, exp_flag};
      REG_ID:       rdat = ID_VALUE;
`ifdef DCPU_TIMER_MISS_COUNT_EN
      REG_MISS:     rdat = miss;
`endif
      default:      rdat = 16'd0;
    endcase
  end

  assign o_dat = rd_stb ? rdat : 16'd0;
  assign o_int = exp_flag & ctrl_ie;

endmodule
